// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - shared binary16 constants, field widths and divider state enum
package fp16_pkg;

  localparam logic [15:0] FP16_QNAN = 16'h7e00;
  localparam logic [14:0] FP16_INF  = 15'h7c00;
  localparam int          FP16_BIAS = 15;
  localparam int          EXP_W     = 5;
  localparam int          FRAC_W    = 10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DIV   = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } div_state_t;

endpackage

// File: rtl/fp16_classify.sv
// rtl/fp16_classify.sv - combinational binary16 field split and zero/inf/nan classification
module fp16_classify
  import fp16_pkg::*;
(
  input  logic [15:0]       x,
  output logic              sign,
  output logic [EXP_W-1:0]  exp,
  output logic [FRAC_W-1:0] frac,
  output logic              is_zero,
  output logic              is_inf,
  output logic              is_nan
);

  assign sign    = x[15];
  assign exp     = x[14:10];
  assign frac    = x[9:0];
  // Subnormals are flushed: exponent 0 means zero regardless of fraction.
  assign is_zero = (exp == '0);
  assign is_inf  = (exp == '1) && (frac == '0);
  assign is_nan  = (exp == '1) && (frac != '0);

endmodule

// File: rtl/fp16_divider_seq.sv
// rtl/fp16_divider_seq.sv - iterative binary16 divider, one restoring quotient bit per cycle
module fp16_divider_seq
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] quo,
  output logic        out_dz
);

  div_state_t state, state_nxt;

  logic              a_sign, b_sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [EXP_W-1:0]  a_exp, b_exp;
  logic [FRAC_W-1:0] a_frac, b_frac;

  fp16_classify u_cls_a (
    .x(a), .sign(a_sign), .exp(a_exp), .frac(a_frac),
    .is_zero(a_zero), .is_inf(a_inf), .is_nan(a_nan)
  );

  fp16_classify u_cls_b (
    .x(b), .sign(b_sign), .exp(b_exp), .frac(b_frac),
    .is_zero(b_zero), .is_inf(b_inf), .is_nan(b_nan)
  );

  logic        accept;
  logic        res_sign;
  logic        spec_nan, spec_hit, spec_dz;
  logic [15:0] spec_quo;

  assign in_ready  = (state == S_IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == S_DONE);
  assign res_sign  = a_sign ^ b_sign;

  assign spec_nan = a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf);
  assign spec_hit = spec_nan || a_zero || b_zero || a_inf || b_inf;
  assign spec_dz  = !spec_nan && b_zero && !a_inf;

  always_comb begin
    spec_quo = {res_sign, 15'h0000};
    if (spec_nan)
      spec_quo = FP16_QNAN;
    else if (b_zero || a_inf)
      spec_quo = {res_sign, FP16_INF};
  end

  logic [11:0]       r, r_sub;
  logic [10:0]       mb;
  logic [13:0]       q;
  logic [3:0]        cnt;
  logic signed [6:0] e;
  logic              sign_q;
  logic              qbit;
  logic [10:0]       mant_n;
  logic              guard, sticky;

  assign qbit  = (r >= {1'b0, mb});
  assign r_sub = qbit ? (r - {1'b0, mb}) : r;

  // Round-to-nearest-even on the normalised mantissa, then range check.
  logic              rnd_inc;
  logic [11:0]       mant_inc;
  logic [10:0]       mant_f;
  logic signed [6:0] e_f;
  logic [15:0]       rnd_quo;

  assign rnd_inc  = guard && (sticky || mant_n[0]);
  assign mant_inc = {1'b0, mant_n} + {11'd0, rnd_inc};

  always_comb begin
    mant_f  = mant_inc[10:0];
    e_f     = e;
    if (mant_inc[11]) begin
      mant_f = 11'd1024;
      e_f    = e + 7'sd1;
    end
    rnd_quo = {sign_q, e_f[4:0], mant_f[9:0]};
    if (e_f >= 7'sd31)
      rnd_quo = {sign_q, FP16_INF};
    else if (e_f <= 7'sd0)
      rnd_quo = {sign_q, 15'h0000};
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = spec_hit ? S_DONE : S_DIV;
      S_DIV:   if (cnt == 4'd13) state_nxt = S_ROUND;
      S_ROUND: if (cnt == 4'd1) state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      quo    <= '0;
      out_dz <= 1'b0;
      r      <= '0;
      mb     <= '0;
      q      <= '0;
      e      <= '0;
      sign_q <= 1'b0;
      mant_n <= '0;
      guard  <= 1'b0;
      sticky <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          sign_q <= res_sign;
          e      <= $signed({2'b00, a_exp} - {2'b00, b_exp} + 7'(FP16_BIAS));
          r      <= {2'b01, a_frac};
          mb     <= {1'b1, b_frac};
          q      <= '0;
          cnt    <= '0;
          if (spec_hit) begin
            quo    <= spec_quo;
            out_dz <= spec_dz;
          end
        end
        S_DIV: begin
          q   <= {q[12:0], qbit};
          r   <= {r_sub[10:0], 1'b0};
          cnt <= (cnt == 4'd13) ? 4'd0 : cnt + 4'd1;
        end
        S_ROUND: begin
          // cnt doubles as the phase: 0 normalises, 1 rounds and publishes.
          if (cnt == 4'd0) begin
            if (q[13]) begin
              mant_n <= q[13:3];
              guard  <= q[2];
              sticky <= (|q[1:0]) || (r != '0);
            end else begin
              mant_n <= q[12:2];
              guard  <= q[1];
              sticky <= q[0] || (r != '0);
              e      <= e - 7'sd1;
            end
            cnt <= 4'd1;
          end else begin
            quo    <= rnd_quo;
            out_dz <= 1'b0;
            cnt    <= 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_divider_seq.sv
// tb/tb_fp16_divider_seq.sv - self-checking bench for fp16_divider_seq
module tb_fp16_divider_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quo;
  logic        out_dz;

  int n_checks = 0;
  int n_pass   = 0;

  fp16_divider_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .quo(quo), .out_dz(out_dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  // Reference: exact rational quotient of the significands, rounded to 11 bits.
  function automatic void ref_div(input logic [15:0] x, input logic [15:0] y,
                                  output logic [15:0] rq, output logic rdz, output logic spec);
    logic sg;
    int   ea, eb, fa, fb, ma, mb, s, mant, rr, e;
    logic [4:0] e5;
    logic [10:0] m11;
    logic a_z, b_z, a_i, b_i, a_n, b_n;
    sg  = x[15] ^ y[15];
    ea  = int'(x[14:10]); eb = int'(y[14:10]);
    fa  = int'(x[9:0]);   fb = int'(y[9:0]);
    a_z = (ea == 0); b_z = (eb == 0);
    a_i = (ea == 31) && (fa == 0); b_i = (eb == 31) && (fb == 0);
    a_n = (ea == 31) && (fa != 0); b_n = (eb == 31) && (fb != 0);
    rdz  = 1'b0;
    spec = 1'b1;
    if (a_n || b_n || (a_z && b_z) || (a_i && b_i)) rq = 16'h7e00;
    else if (b_z) begin rq = {sg, 15'h7c00}; rdz = !a_i; end
    else if (a_i) rq = {sg, 15'h7c00};
    else if (a_z || b_i) rq = {sg, 15'h0000};
    else begin
      spec = 1'b0;
      ma   = 1024 + fa;
      mb   = 1024 + fb;
      s    = (ma >= mb) ? 10 : 11;
      mant = (ma << s) / mb;
      rr   = (ma << s) - mant * mb;
      e    = ea - eb + 15 - ((s == 11) ? 1 : 0);
      if ((2 * rr > mb) || ((2 * rr == mb) && (mant % 2 == 1))) mant++;
      if (mant == 2048) begin mant = 1024; e++; end
      e5  = e[4:0];
      m11 = mant[10:0];
      if (e >= 31)     rq = {sg, 15'h7c00};
      else if (e <= 0) rq = {sg, 15'h0000};
      else             rq = {sg, e5, m11[9:0]};
    end
  endfunction

  task automatic start_op(input string tag, input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    a = x; b = y; in_valid = 1'b1;
    #1 check({tag, " in_ready"}, in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int want_lat,
                             input logic [15:0] want_q, input logic want_dz);
    int lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!out_valid && lat < 40);
    check({tag, " latency"}, lat, want_lat);
    check({tag, " quo"}, quo, want_q);
    check({tag, " dz"}, out_dz, want_dz);
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 check({tag, " drained"}, out_valid, 0);
    check({tag, " idle"}, in_ready, 1);
    out_ready = 1'b0;
  endtask

  task automatic op(input string tag, input logic [15:0] x, input logic [15:0] y,
                    input int want_lat, input logic [15:0] want_q, input logic want_dz);
    start_op(tag, x, y);
    wait_result(tag, want_lat, want_q, want_dz);
    drain(tag);
  endtask

  initial begin
    logic [15:0] rx, ry, rq;
    logic        rdz, rsp;
    logic        seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst in_ready", in_ready, 0);
    check("rst out_valid", out_valid, 0);
    check("rst quo", quo, 16'h0000);
    check("rst dz", out_dz, 0);
    @(negedge clk) rst = 1'b0;
    #1 check("post-rst in_ready", in_ready, 1);

    op("1/2",     16'h3C00, 16'h4000, 16, 16'h3800, 0);
    op("1/3",     16'h3C00, 16'h4200, 16, 16'h3555, 0);
    op("2/1",     16'h4000, 16'h3C00, 16, 16'h4000, 0);
    op("ovf",     16'h7BFF, 16'h3800, 16, 16'h7C00, 0);
    op("unf",     16'h0400, 16'h7BFF, 16, 16'h0000, 0);
    op("neg",     16'h8400, 16'h3C00, 16, 16'h8400, 0);
    op("x/0",     16'h4000, 16'h0000, 1,  16'h7C00, 1);
    op("-x/0",    16'hC000, 16'h0000, 1,  16'hFC00, 1);
    op("0/0",     16'h0000, 16'h0000, 1,  16'h7E00, 0);
    op("inf/inf", 16'h7C00, 16'h7C00, 1,  16'h7E00, 0);
    op("x/inf",   16'h3C00, 16'h7C00, 1,  16'h0000, 0);
    op("ftz",     16'h0001, 16'h3C00, 1,  16'h0000, 0);
    op("inf/0",   16'hFC00, 16'h0000, 1,  16'hFC00, 0);
    op("nan",     16'h7C01, 16'h3C00, 1,  16'h7E00, 0);

    // Backpressure: result held, new operands ignored.
    start_op("bp", 16'h3C00, 16'h4000);
    wait_result("bp", 16, 16'h3800, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 16'h4000; b = 16'h3C00;
      @(posedge clk);
      #1 check("bp hold quo", quo, 16'h3800);
      check("bp hold valid", out_valid, 1);
      check("bp in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    drain("bp");
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1 if (out_valid) seen = 1'b1;
    end
    check("bp no ghost", seen, 0);

    // Reset during DIV with cnt=7.
    start_op("rst-mid", 16'h3C00, 16'h4000);
    repeat (7) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 check("rst-mid valid", out_valid, 0);
    check("rst-mid in_ready", in_ready, 0);
    @(negedge clk) rst = 1'b0;
    #1 check("rst-mid idle", in_ready, 1);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1 if (out_valid) seen = 1'b1;
    end
    check("rst-mid no result", seen, 0);
    op("after-rst", 16'h3C00, 16'h4000, 16, 16'h3800, 0);

    for (int i = 0; i < 150; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      if (i % 4 == 0) ry[14:10] = 5'($urandom_range(10, 20));
      ref_div(rx, ry, rq, rdz, rsp);
      op($sformatf("rnd %h/%h", rx, ry), rx, ry, rsp ? 1 : 16, rq, rdz);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
